// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx among NREQ byte producers.
// Round-robin arbitration with an optional per-owner lock for multi-byte
// messages; each byte is sequenced through the start/ready handshake.
//
// Handshake summary (requester side and transmitter side):
//   A requester raises req[i] with its byte on data_in[8*i+:8] and holds both
//   until gnt[i] pulses for one cycle; in that gnt cycle it may drop req or
//   present its next byte. Nothing is sampled again until the FSM is back in
//   IDLE. Toward the transmitter, tx_start pulses together with gnt and
//   tx_data is held from that cycle until the next grant; the byte is
//   considered accepted when tx_ready falls and the frame complete when
//   tx_ready rises again.
module uart_tx_arbiter #(
  parameter int NREQ = 4  // 2..8 requesters
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   lock,
  input  logic [8*NREQ-1:0] data_in,
  output logic [NREQ-1:0]   gnt,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic [NREQ-1:0]   owner,
  output logic              busy,
  output logic [1:0]        dbg_state_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_LOW  = 2'd2,
    WAIT_HIGH = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] owner_q, owner_d;
  logic            tx_start_q, tx_start_d;
  logic [7:0]      tx_data_q, tx_data_d;
  // Index of the last granted requester; round-robin search starts after it.
  logic [IW-1:0]   last_q, last_d;

  logic [IW-1:0]   win_idx;
  logic [7:0]      win_byte;
  logic            lock_hit;
  logic            rr_found;

  // Winner selection: a locked owner that still requests keeps the
  // transmitter, otherwise first set req after the last owner, wrapping.
  always_comb begin
    win_idx  = '0;
    win_byte = 8'h00;
    lock_hit = 1'b0;
    rr_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (owner_q[k] && lock[k] && req[k]) begin
        win_idx  = IW'(k);
        lock_hit = 1'b1;
      end
    end
    if (!lock_hit) begin
      for (int i = 1; i <= NREQ; i++) begin
        if (!rr_found && req[(int'(last_q) + i) % NREQ]) begin
          win_idx  = IW'((int'(last_q) + i) % NREQ);
          rr_found = 1'b1;
        end
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (win_idx == IW'(k)) begin
        win_byte = data_in[8*k +: 8];
      end
    end
  end

  // Next-state and registered-output logic; gnt/tx_start default to 0 so
  // they can only ever be one-cycle pulses.
  always_comb begin
    state_d    = state_q;
    gnt_d      = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    owner_d    = owner_q;
    last_d     = last_q;
    case (state_q)
      IDLE: begin
        if (tx_ready && (|req)) begin
          gnt_d      = NREQ'(1) << win_idx;
          owner_d    = NREQ'(1) << win_idx;
          tx_start_d = 1'b1;
          tx_data_d  = win_byte;
          last_d     = win_idx;
          state_d    = START;
        end
      end
      START: begin
        state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        // Transmitter drops ready once it has taken the byte.
        if (!tx_ready) begin
          state_d = WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        // Ready returning high marks the end of the frame.
        if (tx_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset leaves requester 0 with top priority.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      owner_q    <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      last_q     <= IW'(NREQ - 1);
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      last_q     <= last_d;
    end
  end

  assign gnt         = gnt_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign owner       = owner_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter (NREQ=4). The bench plays the
// transmitter by driving tx_ready, and plays the producers by driving
// req/lock/data_in. Inputs change and outputs are sampled on negedge.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rstn;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [31:0] data_in;
  logic [3:0]  gnt;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [3:0]  owner;
  logic        busy;
  logic [1:0]  dbg_state;

  logic [7:0]  bytes [4];

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.NREQ(4)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req         (req),
    .lock        (lock),
    .data_in     (data_in),
    .gnt         (gnt),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .owner       (owner),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_data();
    data_in = {bytes[3], bytes[2], bytes[1], bytes[0]};
  endtask

  // Hold reset for two cycles, then release on a negedge.
  task automatic apply_reset();
    rstn     = 1'b0;
    req      = 4'b0000;
    lock     = 4'b0000;
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) bytes[i] = 8'h00;
    drive_data();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // Wait (bounded) for a grant and check it arrived one cycle after IDLE.
  task automatic wait_grant(input logic [3:0] exp_gnt, input logic [7:0] exp_data,
                            input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt === 4'b0000 && n < 20);
    checks++;
    if (gnt === 4'b0000) begin
      errors++;
      $display("FAIL %s_timeout: no gnt after %0d cycles, expected gnt=%b", name, n, exp_gnt);
      return;
    end
    checks++;
    if (n !== 1) begin
      errors++;
      $display("FAIL %s_latency: gnt after %0d cycles, expected 1", name, n);
    end
    checks++;
    if (gnt !== exp_gnt) begin
      errors++;
      $display("FAIL %s_gnt: got %b expected %b", name, gnt, exp_gnt);
    end
    checks++;
    if (tx_start !== 1'b1) begin
      errors++;
      $display("FAIL %s_tx_start: got %b expected 1", name, tx_start);
    end
    checks++;
    if (tx_data !== exp_data) begin
      errors++;
      $display("FAIL %s_tx_data: got %h expected %h", name, tx_data, exp_data);
    end
    checks++;
    if (owner !== exp_gnt || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_owner_busy: got owner=%b busy=%b expected owner=%b busy=1",
               name, owner, busy, exp_gnt);
    end
  endtask

  // Play one transmitter frame after a grant: ready low 4 cycles, then high.
  task automatic finish_frame(input logic [7:0] exp_data, input string name);
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0000 || tx_start !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse: got gnt=%b tx_start=%b expected 0000/0", name, gnt, tx_start);
    end
    tx_ready = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || tx_data !== exp_data) begin
      errors++;
      $display("FAIL %s_in_frame: got busy=%b tx_data=%h expected 1/%h",
               name, busy, tx_data, exp_data);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: got busy=%b expected 0", name, busy);
    end
  endtask

  task automatic test_reset();
    rstn     = 1'b0;
    req      = 4'b0000;
    lock     = 4'b0000;
    tx_ready = 1'b1;
    data_in  = 32'h0;
    repeat (2) @(negedge clk);
    checks++;
    if (gnt !== 4'b0000 || tx_start !== 1'b0 || tx_data !== 8'h00 ||
        owner !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: got gnt=%b start=%b data=%h owner=%b busy=%b expected all zero",
               gnt, tx_start, tx_data, owner, busy);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    apply_reset();
    bytes[0] = 8'h41;
    drive_data();
    req = 4'b0001;
    wait_grant(4'b0001, 8'h41, "single");
    req = 4'b0000;
    finish_frame(8'h41, "single");
  endtask

  task automatic test_round_robin();
    int w;
    apply_reset();
    for (int i = 0; i < 4; i++) bytes[i] = 8'h10 * 8'(i + 1);
    drive_data();
    req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      w = k % 4;
      wait_grant(4'b0001 << w, bytes[w], "rr");
      bytes[w] = bytes[w] + 8'h01;
      drive_data();
      finish_frame(bytes[w] - 8'h01, "rr");
    end
    req = 4'b0000;
  endtask

  task automatic test_wrap();
    int order [4] = '{3, 0, 1, 3};
    int w;
    apply_reset();
    bytes[2] = 8'h22;
    drive_data();
    req = 4'b0100;
    wait_grant(4'b0100, 8'h22, "wrap_own2");
    bytes[0] = 8'h30;
    bytes[1] = 8'h31;
    bytes[3] = 8'h33;
    drive_data();
    req = 4'b1011;
    finish_frame(8'h22, "wrap_own2");
    for (int k = 0; k < 4; k++) begin
      w = order[k];
      wait_grant(4'b0001 << w, bytes[w], "wrap");
      bytes[w] = bytes[w] + 8'h01;
      drive_data();
      finish_frame(bytes[w] - 8'h01, "wrap");
    end
    req = 4'b0000;
  endtask

  task automatic test_lock();
    apply_reset();
    bytes[1] = 8'h50;
    drive_data();
    req  = 4'b0010;
    lock = 4'b0010;
    wait_grant(4'b0010, 8'h50, "lock_first");
    bytes[0] = 8'h60;
    bytes[1] = 8'h51;
    drive_data();
    req = 4'b0011;
    finish_frame(8'h50, "lock_first");
    for (int k = 0; k < 3; k++) begin
      wait_grant(4'b0010, bytes[1], "lock_hold");
      bytes[1] = bytes[1] + 8'h01;
      drive_data();
      if (k == 2) lock = 4'b0000;
      finish_frame(bytes[1] - 8'h01, "lock_hold");
    end
    wait_grant(4'b0001, 8'h60, "lock_release");
    req = 4'b0000;
    finish_frame(8'h60, "lock_release");
  endtask

  task automatic test_ready_gating();
    apply_reset();
    bytes[2] = 8'h77;
    drive_data();
    tx_ready = 1'b0;
    req      = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0000 || tx_start !== 1'b0) begin
        errors++;
        $display("FAIL gate_hold: got gnt=%b tx_start=%b expected 0000/0", gnt, tx_start);
      end
    end
    tx_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0100 || tx_start !== 1'b1 || tx_data !== 8'h77) begin
      errors++;
      $display("FAIL gate_release: got gnt=%b start=%b data=%h expected 0100/1/77",
               gnt, tx_start, tx_data);
    end
    req = 4'b0000;
    finish_frame(8'h77, "gate");
  endtask

  task automatic test_withdraw();
    apply_reset();
    tx_ready = 1'b0;
    req      = 4'b0010;
    repeat (2) @(negedge clk);
    req      = 4'b0000;
    tx_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0000 || busy !== 1'b0) begin
        errors++;
        $display("FAIL withdraw: got gnt=%b busy=%b expected 0000/0", gnt, busy);
      end
    end
    bytes[0] = 8'h05;
    bytes[1] = 8'h06;
    drive_data();
    req = 4'b0011;
    wait_grant(4'b0001, 8'h05, "withdraw_next");
    req = 4'b0000;
    finish_frame(8'h05, "withdraw_next");
  endtask

  task automatic test_async_reset();
    apply_reset();
    bytes[0] = 8'h11;
    drive_data();
    req = 4'b0001;
    wait_grant(4'b0001, 8'h11, "areset_pre");
    req = 4'b0000;
    @(negedge clk);
    tx_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || dbg_state !== 2'd3) begin
      errors++;
      $display("FAIL areset_wait_high: got busy=%b state=%0d expected 1/3", busy, dbg_state);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0000 || tx_start !== 1'b0 || tx_data !== 8'h00 ||
        owner !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL areset_during: got gnt=%b start=%b data=%h owner=%b busy=%b expected all zero",
               gnt, tx_start, tx_data, owner, busy);
    end
    @(negedge clk);
    rstn     = 1'b1;
    tx_ready = 1'b1;
    bytes[0] = 8'h12;
    bytes[3] = 8'h13;
    drive_data();
    req = 4'b1001;
    wait_grant(4'b0001, 8'h12, "areset_after");
    req = 4'b0000;
    finish_frame(8'h12, "areset_after");
  endtask

  // Test sequence and final report.
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_lock();
    test_ready_gating();
    test_withdraw();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
